// File: rtl/sm_fixmul_pipe_if.sv
// Operand/result handshake bundle for sm_fixmul_pipe.
// master drives operands and out_ready; slave is the multiplier.
interface sm_fixmul_pipe_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_sat;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result, out_sat
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result, out_sat
    );
endinterface

// File: rtl/sm_fixmul_pipe.sv
// Saturating sign-magnitude fixed-point multiplier, LATENCY stages, bubble-collapsing valid/ready;
// in_ready drops only when every stage is full and out_ready=0. SM_FIXMUL_ROUND_EN selects round-half-up on the magnitude.
module sm_fixmul_pipe #(
    parameter int W       = 16,
    parameter int FRAC    = 8,
    parameter int LATENCY = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    sm_fixmul_pipe_if.slave  bus,
    output logic [CNT_W-1:0] sat_count,
    input  logic             sat_clr
);
    localparam int MW = W - 1;
    localparam int PW = 2 * MW;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PW-1:0] prod;
    logic [PW-1:0] prod_adj;
    logic [PW-1:0] mag_full;
    logic [MW-1:0] mag;
    logic          sat_now;
    logic          sign_now;
    logic [W-1:0]  res_new;

`ifdef SM_FIXMUL_ROUND_EN
    localparam logic [PW-1:0] HALF = PW'(1) << (FRAC - 1);
`endif

    // Full arithmetic is done ahead of stage 0; later stages only carry the result.
    always_comb begin
        prod = PW'(bus.in_a[MW-1:0]) * PW'(bus.in_b[MW-1:0]);
`ifdef SM_FIXMUL_ROUND_EN
        prod_adj = prod + HALF;
`else
        prod_adj = prod;
`endif
        mag_full = prod_adj >> FRAC;
        sat_now  = |mag_full[PW-1:MW];
        mag      = sat_now ? '1 : mag_full[MW-1:0];
        sign_now = (bus.in_a[W-1] ^ bus.in_b[W-1]) & (|mag);
        res_new  = {sign_now, mag};
    end

    logic [LATENCY-1:0] vld_q, vld_d;
    logic [LATENCY-1:0] sat_q, sat_d;
    logic [W-1:0]       res_q [LATENCY];
    logic [W-1:0]       res_d [LATENCY];
    logic [LATENCY-1:0] free;
    logic               chain;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // A stage can load when it is empty or its content moves on; this ripples back from out_ready.
    always_comb begin
        chain = bus.out_ready;
        free  = '0;
        for (int i = LATENCY - 1; i >= 0; i--) begin
            free[i] = !vld_q[i] || chain;
            chain   = free[i];
        end
    end

    always_comb begin
        vld_d = vld_q;
        sat_d = sat_q;
        for (int i = 0; i < LATENCY; i++) begin
            res_d[i] = res_q[i];
        end
        if (free[0]) begin
            vld_d[0] = bus.in_valid;
            if (bus.in_valid) begin
                res_d[0] = res_new;
                sat_d[0] = sat_now;
            end
        end
        for (int i = 1; i < LATENCY; i++) begin
            if (free[i]) begin
                vld_d[i] = vld_q[i-1];
                if (vld_q[i-1]) begin
                    res_d[i] = res_q[i-1];
                    sat_d[i] = sat_q[i-1];
                end
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (sat_clr) begin
            cnt_d = '0;
        end else if (vld_q[LATENCY-1] && bus.out_ready && sat_q[LATENCY-1] && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            sat_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                res_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            sat_q <= sat_d;
            cnt_q <= cnt_d;
            for (int i = 0; i < LATENCY; i++) begin
                res_q[i] <= res_d[i];
            end
        end
    end

    assign bus.in_ready   = free[0];
    assign bus.out_valid  = vld_q[LATENCY-1];
    assign bus.out_result = res_q[LATENCY-1];
    assign bus.out_sat    = sat_q[LATENCY-1];
    assign sat_count      = cnt_q;
endmodule

// File: tb/tb_sm_fixmul_pipe.sv
// Bench for sm_fixmul_pipe: a LATENCY=2 instance for directed/latency cases and a
// LATENCY=3, CNT_W=3 instance for random backpressure, counter saturation and reset.
module tb_sm_fixmul_pipe;
    localparam int L2 = 2;
    localparam int L3 = 3;
`ifdef SM_FIXMUL_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif
    localparam logic [15:0] RND_EXP = ROUND ? 16'h0001 : 16'h0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sm_fixmul_pipe_if #(.W(16)) b2 ();
    sm_fixmul_pipe_if #(.W(16)) b3 ();
    logic        clr2 = 1'b0;
    logic        clr3 = 1'b0;
    logic [15:0] cnt2;
    logic [2:0]  cnt3;

    sm_fixmul_pipe #(.W(16), .FRAC(8), .LATENCY(L2), .CNT_W(16)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .bus(b2.slave), .sat_count(cnt2), .sat_clr(clr2));
    sm_fixmul_pipe #(.W(16), .FRAC(8), .LATENCY(L3), .CNT_W(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .bus(b3.slave), .sat_count(cnt3), .sat_clr(clr3));

    int ntot = 0;
    int npass = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    // Reference: {sat, sign, magnitude} from plain integer arithmetic on the Q7.8 values.
    function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b);
        longint unsigned p, m;
        logic [14:0] mag;
        logic s;
        p = longint'(a[14:0]) * longint'(b[14:0]);
        if (ROUND) p = p + 128;
        m = p / 256;
        s = (m > 32767);
        mag = s ? 15'h7FFF : 15'(m);
        return {s, (a[15] ^ b[15]) && (mag != 0), mag};
    endfunction

    typedef struct { logic [16:0] e; int acc; } ent_t;
    ent_t q2[$];
    ent_t q3[$];
    int m2 = 0, m3 = 0;
    logic st2 = 0, st3 = 0;
    logic [16:0] h2, h3;

    always @(negedge clk) begin
        if (!rst_n) begin
            q2.delete(); m2 = 0; st2 = 0;
        end else begin
            chk("d2 in_ready", b2.in_ready, (q2.size() < L2) || b2.out_ready);
            chk("d2 sat_count", cnt2, m2);
            if (st2) chk("d2 hold", {b2.out_valid, b2.out_sat, b2.out_result}, {1'b1, h2});
            if (b2.out_valid) begin
                chk("d2 spurious", q2.size() != 0, 1);
                if (q2.size() != 0) begin
                    chk("d2 result", {b2.out_sat, b2.out_result}, q2[0].e);
                    if (b2.out_ready) begin
                        chk("d2 latency", cyc - q2[0].acc, L2);
                        if (q2[0].e[16] && m2 < 65535) m2++;
                        void'(q2.pop_front());
                    end
                end
            end
            if (clr2) m2 = 0;
            if (b2.in_valid && b2.in_ready) q2.push_back('{model(b2.in_a, b2.in_b), cyc});
            st2 = b2.out_valid && !b2.out_ready;
            h2 = {b2.out_sat, b2.out_result};
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            q3.delete(); m3 = 0; st3 = 0;
        end else begin
            chk("d3 in_ready", b3.in_ready, (q3.size() < L3) || b3.out_ready);
            chk("d3 sat_count", cnt3, m3);
            if (st3) chk("d3 hold", {b3.out_valid, b3.out_sat, b3.out_result}, {1'b1, h3});
            if (b3.out_valid) begin
                chk("d3 spurious", q3.size() != 0, 1);
                if (q3.size() != 0) begin
                    chk("d3 result", {b3.out_sat, b3.out_result}, q3[0].e);
                    if (b3.out_ready) begin
                        if (q3[0].e[16] && m3 < 7) m3++;
                        void'(q3.pop_front());
                    end
                end
            end
            if (clr3) m3 = 0;
            if (b3.in_valid && b3.in_ready) q3.push_back('{model(b3.in_a, b3.in_b), cyc});
            st3 = b3.out_valid && !b3.out_ready;
            h3 = {b3.out_sat, b3.out_result};
        end
    end

    // One operand pair through the LATENCY=2 instance with literal expectations.
    task automatic run2(input logic [15:0] a, input logic [15:0] b, input logic [15:0] r,
                        input logic s, input logic clr_at_out, input string nm);
        int k;
        b2.in_valid = 1'b1; b2.in_a = a; b2.in_b = b;
        @(posedge clk); #1;
        b2.in_valid = 1'b0; b2.in_a = 16'($urandom); b2.in_b = 16'($urandom);
        k = 0;
        while (!b2.out_valid && k < 10) begin @(posedge clk); #1; k++; end
        chk({nm, " lat"}, k, 1);
        chk({nm, " res"}, b2.out_result, r);
        chk({nm, " sat"}, b2.out_sat, s);
        clr2 = clr_at_out;
        @(posedge clk); #1;
        clr2 = 1'b0;
    endtask

    logic tog_en = 1'b0;
    logic clr_en = 1'b0;

    task automatic send3(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            logic acc;
            int k;
            b3.in_valid = 1'b1;
            if (mode == 1) begin
                b3.in_a = {1'($urandom), 1'b1, 14'($urandom)};
                b3.in_b = {1'($urandom), 15'($urandom_range(16'h0200, 16'h7FFF))};
            end else begin
                b3.in_a = 16'($urandom);
                b3.in_b = ($urandom_range(0, 1) == 1) ? 16'($urandom)
                                                      : {1'($urandom), 15'($urandom_range(0, 1023))};
            end
            acc = 1'b0; k = 0;
            while (!acc && k < 60) begin
                @(negedge clk); acc = b3.in_ready;
                @(posedge clk); #1; k++;
            end
            chk("d3 accepted", acc, 1);
        end
        b3.in_valid = 1'b0; b3.in_a = 16'($urandom); b3.in_b = 16'($urandom);
    endtask

    task automatic drain3();
        int k;
        tog_en = 1'b0;
        #1;
        b3.out_ready = 1'b1; clr3 = 1'b0;
        k = 0;
        while (q3.size() != 0 && k < 40) begin @(posedge clk); #1; k++; end
        chk("d3 drained", q3.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        b2.in_valid = 0; b2.out_ready = 1; b2.in_a = 16'hDEAD; b2.in_b = 16'hBEEF;
        b3.in_valid = 0; b3.out_ready = 1; b3.in_a = 16'h1234; b3.in_b = 16'h5678;
        #12;
        chk("rst d2 out_valid", b2.out_valid, 0);
        chk("rst d2 out_result", b2.out_result, 0);
        chk("rst d2 out_sat", b2.out_sat, 0);
        chk("rst d2 sat_count", cnt2, 0);
        chk("rst d3 out_valid", b3.out_valid, 0);
        chk("rst d3 sat_count", cnt3, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("rst d2 in_ready", b2.in_ready, 1);
        chk("rst d3 in_ready", b3.in_ready, 1);
        @(posedge clk); #1;

        run2(16'h0180, 16'h0200, 16'h0300, 1'b0, 1'b0, "pos");
        run2(16'h8180, 16'h0200, 16'h8300, 1'b0, 1'b0, "mixed");
        run2(16'h7F00, 16'h0200, 16'h7FFF, 1'b1, 1'b0, "sat pos");
        run2(16'hFF00, 16'h0200, 16'hFFFF, 1'b1, 1'b0, "sat neg");
        chk("sat_count two", cnt2, 2);
        clr2 = 1'b1; @(posedge clk); #1; clr2 = 1'b0;
        chk("sat_count cleared", cnt2, 0);
        run2(16'h8001, 16'h0001, 16'h0000, 1'b0, 1'b0, "negzero");
        run2(16'h0001, 16'h0080, RND_EXP, 1'b0, 1'b0, "round");
        run2(16'h8000, 16'h1234, 16'h0000, 1'b0, 1'b0, "zero op");
        run2(16'h7FFF, 16'h0100, 16'h7FFF, 1'b0, 1'b0, "max nosat");
        run2(16'h4000, 16'h0200, 16'h7FFF, 1'b1, 1'b1, "just sat");
        chk("clr beats incr", cnt2, 0);

        for (int i = 0; i < 6; i++) begin
            b2.in_valid = 1'b1; b2.in_a = 16'($urandom); b2.in_b = 16'($urandom_range(0, 16'hFFFF));
            @(posedge clk); #1;
        end
        b2.in_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        chk("d2 stream drained", q2.size(), 0);

        fork
            forever begin
                @(posedge clk); #1;
                if (tog_en) begin
                    b3.out_ready = 1'($urandom);
                    clr3 = clr_en && ($urandom_range(0, 15) == 0);
                end
            end
        join_none

        tog_en = 1'b1; clr_en = 1'b0;
        send3(8, 0);
        drain3();
        tog_en = 1'b1;
        send3(20, 1);
        drain3();
        chk("d3 cnt saturates", cnt3, 7);
        tog_en = 1'b1; clr_en = 1'b1;
        send3(12, 0);
        drain3();

        b3.out_ready = 1'b0;
        send3(2, 1);
        chk("d3 inflight", q3.size(), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst out_valid", b3.out_valid, 0);
        chk("midrst sat_count", cnt3, 0);
        chk("midrst out_result", b3.out_result, 0);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        b3.out_ready = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        send3(1, 0);
        drain3();

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
